// File: rtl/mem_port_arbiter.sv
// Three-way line-request arbiter (IC, DC, INTR) in front of the unified memory port.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin priority; default is fixed INTR > DC > IC.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IC_EN,
  input  logic              DC_EN,
  input  logic              INTR_EN,
  input  logic              IC_WR,
  input  logic              DC_WR,
  input  logic              INTR_WR,
  input  logic [ADDR_W-1:0] IC_A,
  input  logic [ADDR_W-1:0] DC_A,
  input  logic [ADDR_W-1:0] INTR_A,
  input  logic [DATA_W-1:0] IC_WRITE_DATA,
  input  logic [DATA_W-1:0] DC_WRITE_DATA,
  input  logic [DATA_W-1:0] INTR_WRITE_DATA,
  output logic              IC_R,
  output logic              DC_R,
  output logic              INTR_R,
  output logic [DATA_W-1:0] IC_READ_DATA,
  output logic [DATA_W-1:0] DC_READ_DATA,
  output logic [DATA_W-1:0] INTR_READ_DATA,
  output logic              MEM_EN,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [DATA_W-1:0] MEM_WRITE_DATA,
  input  logic [DATA_W-1:0] MEM_READ_DATA,
  input  logic              MEM_R,
  output logic [1:0]        GNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IC   = 2'd1;
  localparam logic [1:0] G_DC   = 2'd2;
  localparam logic [1:0] G_INTR = 2'd3;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ic_r_q, ic_r_d;
  logic                dc_r_q, dc_r_d;
  logic                intr_r_q, intr_r_d;
  logic [DATA_W-1:0]   ic_rd_q, ic_rd_d;
  logic [DATA_W-1:0]   dc_rd_q, dc_rd_d;
  logic [DATA_W-1:0]   intr_rd_q, intr_rd_d;
  logic [1:0]          win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]          rr_q, rr_d;

  // Winner search starts just after the requester granted last.
  always_comb begin
    win = G_NONE;
    case (rr_q)
      G_IC: begin
        if (DC_EN) win = G_DC;
        else if (INTR_EN) win = G_INTR;
        else if (IC_EN) win = G_IC;
        else win = G_NONE;
      end
      G_DC: begin
        if (INTR_EN) win = G_INTR;
        else if (IC_EN) win = G_IC;
        else if (DC_EN) win = G_DC;
        else win = G_NONE;
      end
      default: begin
        if (IC_EN) win = G_IC;
        else if (DC_EN) win = G_DC;
        else if (INTR_EN) win = G_INTR;
        else win = G_NONE;
      end
    endcase
  end
`else
  // Fixed priority: INTR over DC over IC.
  always_comb begin
    win = G_NONE;
    if (INTR_EN) win = G_INTR;
    else if (DC_EN) win = G_DC;
    else if (IC_EN) win = G_IC;
    else win = G_NONE;
  end
`endif

  // Next-state and next-output computation for the grant/request/response sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    mem_en_d  = mem_en_q;
    wr_d      = wr_q;
    a_d       = a_q;
    wdata_d   = wdata_q;
    ic_r_d    = 1'b0;
    dc_r_d    = 1'b0;
    intr_r_d  = 1'b0;
    ic_rd_d   = ic_rd_q;
    dc_rd_d   = dc_rd_q;
    intr_rd_d = intr_rd_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win != G_NONE) begin
          state_d  = REQ;
          gnt_d    = win;
          mem_en_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d     = win;
`endif
          // Request fields are frozen here; later requester changes are ignored.
          case (win)
            G_IC: begin
              wr_d    = IC_WR;
              a_d     = IC_A;
              wdata_d = IC_WRITE_DATA;
            end
            G_DC: begin
              wr_d    = DC_WR;
              a_d     = DC_A;
              wdata_d = DC_WRITE_DATA;
            end
            G_INTR: begin
              wr_d    = INTR_WR;
              a_d     = INTR_A;
              wdata_d = INTR_WRITE_DATA;
            end
            default: begin
              wr_d    = wr_q;
              a_d     = a_q;
              wdata_d = wdata_q;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (MEM_R) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          case (gnt_q)
            G_IC: begin
              ic_r_d = 1'b1;
              if (!wr_q) ic_rd_d = MEM_READ_DATA;
              else ic_rd_d = ic_rd_q;
            end
            G_DC: begin
              dc_r_d = 1'b1;
              if (!wr_q) dc_rd_d = MEM_READ_DATA;
              else dc_rd_d = dc_rd_q;
            end
            G_INTR: begin
              intr_r_d = 1'b1;
              if (!wr_q) intr_rd_d = MEM_READ_DATA;
              else intr_rd_d = intr_rd_q;
            end
            default: begin
              ic_r_d = 1'b0;
            end
          endcase
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = G_NONE;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = G_NONE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      gnt_q     <= G_NONE;
      mem_en_q  <= 1'b0;
      wr_q      <= 1'b0;
      a_q       <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      ic_r_q    <= 1'b0;
      dc_r_q    <= 1'b0;
      intr_r_q  <= 1'b0;
      ic_rd_q   <= {DATA_W{1'b0}};
      dc_rd_q   <= {DATA_W{1'b0}};
      intr_rd_q <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      rr_q      <= G_INTR;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mem_en_q  <= mem_en_d;
      wr_q      <= wr_d;
      a_q       <= a_d;
      wdata_q   <= wdata_d;
      ic_r_q    <= ic_r_d;
      dc_r_q    <= dc_r_d;
      intr_r_q  <= intr_r_d;
      ic_rd_q   <= ic_rd_d;
      dc_rd_q   <= dc_rd_d;
      intr_rd_q <= intr_rd_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign MEM_EN         = mem_en_q;
  assign MEM_WR         = wr_q;
  assign MEM_A          = a_q;
  assign MEM_WRITE_DATA = wdata_q;
  assign GNT            = gnt_q;
  assign IC_R           = ic_r_q;
  assign DC_R           = dc_r_q;
  assign INTR_R         = intr_r_q;
  assign IC_READ_DATA   = ic_rd_q;
  assign DC_READ_DATA   = dc_rd_q;
  assign INTR_READ_DATA = intr_rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected grant orders follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          IC_EN = 1'b0, DC_EN = 1'b0, INTR_EN = 1'b0;
  logic          IC_WR = 1'b0, DC_WR = 1'b0, INTR_WR = 1'b0;
  logic [AW-1:0] IC_A = '0, DC_A = '0, INTR_A = '0;
  logic [DW-1:0] IC_WRITE_DATA = '0, DC_WRITE_DATA = '0, INTR_WRITE_DATA = '0;
  logic          IC_R, DC_R, INTR_R;
  logic [DW-1:0] IC_READ_DATA, DC_READ_DATA, INTR_READ_DATA;
  logic          MEM_EN, MEM_WR;
  logic [AW-1:0] MEM_A;
  logic [DW-1:0] MEM_WRITE_DATA;
  logic [DW-1:0] MEM_READ_DATA = '0;
  logic          MEM_R = 1'b0;
  logic [1:0]    GNT;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IC_EN(IC_EN), .DC_EN(DC_EN), .INTR_EN(INTR_EN),
    .IC_WR(IC_WR), .DC_WR(DC_WR), .INTR_WR(INTR_WR),
    .IC_A(IC_A), .DC_A(DC_A), .INTR_A(INTR_A),
    .IC_WRITE_DATA(IC_WRITE_DATA), .DC_WRITE_DATA(DC_WRITE_DATA), .INTR_WRITE_DATA(INTR_WRITE_DATA),
    .IC_R(IC_R), .DC_R(DC_R), .INTR_R(INTR_R),
    .IC_READ_DATA(IC_READ_DATA), .DC_READ_DATA(DC_READ_DATA), .INTR_READ_DATA(INTR_READ_DATA),
    .MEM_EN(MEM_EN), .MEM_WR(MEM_WR), .MEM_A(MEM_A), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA(MEM_READ_DATA), .MEM_R(MEM_R), .GNT(GNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] g);
    case (g)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Wait for the grant, check the memory request, answer after `waits` extra cycles, check the response.
  task automatic serve(input string tag, input logic [1:0] g, input logic [15:0] a, input logic wr,
                       input logic [127:0] wd, input int waits, input logic [127:0] rd, input bit drop);
    int n;
    logic [127:0] got;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MEM_EN && n < 20);
    chk({tag, "_mem_en"}, 128'(MEM_EN), 128'd1);
    chk({tag, "_gnt"}, 128'(GNT), 128'(g));
    chk({tag, "_mem_a"}, 128'(MEM_A), 128'(a));
    chk({tag, "_mem_wr"}, 128'(MEM_WR), 128'(wr));
    chk({tag, "_mem_wd"}, MEM_WRITE_DATA, wd);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      chk({tag, "_wait_en"}, 128'(MEM_EN), 128'd1);
      chk({tag, "_wait_r"}, 128'({INTR_R, DC_R, IC_R}), 128'd0);
    end
    MEM_R = 1'b1;
    MEM_READ_DATA = rd;
    @(negedge CLK);
    MEM_R = 1'b0;
    MEM_READ_DATA = {8{16'hBAD0}};
    chk({tag, "_resp_r"}, 128'({INTR_R, DC_R, IC_R}), 128'(onehot(g)));
    chk({tag, "_resp_en"}, 128'(MEM_EN), 128'd0);
    chk({tag, "_resp_gnt"}, 128'(GNT), 128'(g));
    case (g)
      2'd1:    got = IC_READ_DATA;
      2'd2:    got = DC_READ_DATA;
      2'd3:    got = INTR_READ_DATA;
      default: got = '0;
    endcase
    if (!wr) chk({tag, "_rdata"}, got, rd);
    if (drop) begin
      case (g)
        2'd1:    IC_EN = 1'b0;
        2'd2:    DC_EN = 1'b0;
        2'd3:    INTR_EN = 1'b0;
        default: IC_EN = 1'b0;
      endcase
    end
    @(negedge CLK);
    chk({tag, "_idle_r"}, 128'({INTR_R, DC_R, IC_R}), 128'd0);
    chk({tag, "_idle_gnt"}, 128'(GNT), 128'd0);
  endtask

  function automatic logic [15:0] addr_of(input logic [1:0] g);
    case (g)
      2'd1:    return 16'h0011;
      2'd2:    return 16'h0022;
      2'd3:    return 16'h0033;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [127:0] wd_of(input logic [1:0] g);
    case (g)
      2'd1:    return 128'h1111;
      2'd2:    return 128'h2222;
      2'd3:    return 128'h3333;
      default: return 128'h0;
    endcase
  endfunction

  logic [1:0] ord3 [3];
  logic [1:0] ord6 [6];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    ord3 = '{2'd1, 2'd2, 2'd3};
    ord6 = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
    ord3 = '{2'd3, 2'd2, 2'd1};
    ord6 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_mem_en", 128'(MEM_EN), 128'd0);
    chk("rst_mem_wr", 128'(MEM_WR), 128'd0);
    chk("rst_mem_a", 128'(MEM_A), 128'd0);
    chk("rst_mem_wd", MEM_WRITE_DATA, 128'd0);
    chk("rst_gnt", 128'(GNT), 128'd0);
    chk("rst_r", 128'({INTR_R, DC_R, IC_R}), 128'd0);
    chk("rst_ic_rd", IC_READ_DATA, 128'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Single IC read, two wait cycles
    IC_EN = 1'b1; IC_WR = 1'b0; IC_A = 16'h0040; IC_WRITE_DATA = 128'h77;
    serve("ic_read", 2'd1, 16'h0040, 1'b0, 128'h77, 2, {16{8'hA5}}, 1'b1);

    // DC write: read data unchanged, other requester's data held
    DC_EN = 1'b1; DC_WR = 1'b1; DC_A = 16'h1234; DC_WRITE_DATA = 128'h1;
    serve("dc_write", 2'd2, 16'h1234, 1'b1, 128'h1, 0, 128'hFEED, 1'b1);
    chk("dc_write_rd_kept", DC_READ_DATA, 128'd0);
    chk("ic_rd_held", IC_READ_DATA, {16{8'hA5}});

    // Stray MEM_R in IDLE
    MEM_R = 1'b1;
    @(negedge CLK);
    MEM_R = 1'b0;
    chk("stray_r", 128'({INTR_R, DC_R, IC_R}), 128'd0);
    chk("stray_gnt", 128'(GNT), 128'd0);
    chk("stray_en", 128'(MEM_EN), 128'd0);
    @(negedge CLK);
    chk("stray_r2", 128'({INTR_R, DC_R, IC_R}), 128'd0);

    // DC address changed after grant
    DC_EN = 1'b1; DC_WR = 1'b0; DC_A = 16'h0100;
    @(negedge CLK);
    chk("hold_granted", 128'(MEM_EN), 128'd1);
    DC_A = 16'hFFFF; DC_WR = 1'b1; DC_WRITE_DATA = 128'h99;
    serve("dc_hold", 2'd2, 16'h0100, 1'b0, 128'h1, 1, 128'h0123_4567_89AB_CDEF, 1'b1);

    // Reset during REQ with DC read outstanding
    DC_WR = 1'b0; DC_A = 16'h0200; DC_WRITE_DATA = 128'h5; DC_EN = 1'b1;
    @(negedge CLK);
    chk("mid_req_en", 128'(MEM_EN), 128'd1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_en", 128'(MEM_EN), 128'd0);
    chk("mid_rst_gnt", 128'(GNT), 128'd0);
    DC_EN = 1'b0;
    MEM_R = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_rst_dc_r", 128'(DC_R), 128'd0);
    end
    MEM_R = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_dc_r", 128'(DC_R), 128'd0);
    DC_EN = 1'b1;
    serve("dc_after_rst", 2'd2, 16'h0200, 1'b0, 128'h5, 0, 128'hC0FFEE, 1'b1);

    // All three simultaneously, from a fresh reset
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    IC_WR = 1'b0; DC_WR = 1'b0; INTR_WR = 1'b0;
    IC_A = addr_of(2'd1); DC_A = addr_of(2'd2); INTR_A = addr_of(2'd3);
    IC_WRITE_DATA = wd_of(2'd1); DC_WRITE_DATA = wd_of(2'd2); INTR_WRITE_DATA = wd_of(2'd3);
    IC_EN = 1'b1; DC_EN = 1'b1; INTR_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serve("sim3", ord3[i], addr_of(ord3[i]), 1'b0, wd_of(ord3[i]), 1, 128'hD00D_0000 + 128'(i), 1'b1);
    end
    chk("sim3_done_en", 128'({INTR_EN, DC_EN, IC_EN}), 128'd0);

    // All three held across six transactions, from a fresh reset
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    IC_EN = 1'b1; DC_EN = 1'b1; INTR_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve("held6", ord6[i], addr_of(ord6[i]), 1'b0, wd_of(ord6[i]), 0, 128'hBEEF_0000 + 128'(i), 1'b0);
    end
    IC_EN = 1'b0; DC_EN = 1'b0; INTR_EN = 1'b0;
    @(negedge CLK);
    chk("held6_end_gnt", 128'(GNT), 128'd0);
    chk("held6_end_en", 128'(MEM_EN), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Three-way request arbiter that sits directly upstream of the unified memory. It muxes the ICACHE, DCACHE and interrupt (INTR) line-request ports onto a single memory port. Each transaction is 128-bit and is held to completion before the next grant. Responses are routed back as a one-cycle ready pulse to the granted requester only.

Parameters:
ADDR_W, 16, line address width for all ports
DATA_W, 128, line data width for all ports

Ports:
CLK  in  1  sole clock; all logic is rising-edge
RST  in  1  asynchronous, active-low reset
IC_EN / DC_EN / INTR_EN  in  1 each  request valid, held until matching _R pulse
IC_WR / DC_WR / INTR_WR  in  1 each  1=write, 0=read; stable while _EN high
IC_A / DC_A / INTR_A  in  ADDR_W each  request address
IC_WRITE_DATA / DC_WRITE_DATA / INTR_WRITE_DATA  in  DATA_W each  write data
IC_R / DC_R / INTR_R  out  1 each  one-cycle completion pulse
IC_READ_DATA / DC_READ_DATA / INTR_READ_DATA  out  DATA_W each  read data; valid only in _R cycle
MEM_EN  out  1  memory request
MEM_WR  out  1  memory write enable
MEM_A  out  ADDR_W  memory address
MEM_WRITE_DATA  out  DATA_W  memory write data
MEM_READ_DATA  in  DATA_W  memory read data, valid with MEM_R
MEM_R  in  1  memory ready
GNT  out  2  current owner: 0 none, 1 IC, 2 DC, 3 INTR

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; RR pointer = INTR (IC is next highest).
- FSM states:
  - IDLE: if any _EN is high at a rising edge, pick a winner, register its WR/A/WRITE_DATA, set GNT, go to REQ.
  - REQ: MEM_EN=1 with the registered fields. Ignore MEM_R in all other states. When MEM_R=1 at an edge, register MEM_READ_DATA into the winner's _READ_DATA, go to RESP.
  - RESP: MEM_EN=0; winner's _R=1 for exactly one cycle; GNT held. Next edge returns to IDLE and sets GNT=0.
- Latency: request sampled at edge t gives MEM_EN high in cycle t+1. MEM_R sampled at edge m gives _R in cycle m+1. Minimum round trip is 3 cycles with zero-wait memory.
- Fields are captured at grant. Requester changes to WR/A/data while waiting are ignored.
- Requester protocol: the requester must drop _EN at the edge that ends its _R cycle. An _EN still high in IDLE is a new request.
- Non-granted _R outputs stay 0. Non-granted _READ_DATA outputs hold their last value.
- Write transactions still wait for MEM_R. _READ_DATA is unchanged on write completion.
- Default (fixed) priority: INTR > DC > IC.
- Simultaneous requests: exactly one grant per IDLE cycle. The losers stay pending and are re-evaluated in the next IDLE.
- MEM_R high in IDLE or RESP: ignored, no state change.
- Reset mid-transaction: immediately abandon; MEM_EN and all _R go to 0; no response is delivered.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round-robin priority. The requester granted last has the lowest priority next; rotation order is IC -> DC -> INTR -> IC. The pointer updates on entry to REQ.
- Undefined: fixed priority INTR > DC > IC, and no pointer register exists.

Test Plan:
- Single IC read of A=16'h0040, memory returns 128'hA5..A5 after 2 wait cycles -> MEM_EN high for 3 cycles, MEM_A=16'h0040, MEM_WR=0, IC_R high 1 cycle with IC_READ_DATA=128'hA5..A5, GNT 1 then 0.
- DC write A=16'h1234, data 128'h1 -> MEM_WR=1, MEM_WRITE_DATA=128'h1, DC_R pulses once, DC_READ_DATA unchanged.
- IC, DC and INTR all asserted in the same cycle (fixed priority) -> grant order INTR, DC, IC; three distinct _R pulses; at most one MEM transaction in flight at a time.
- With ARB_ROUND_ROBIN_EN defined, all three requests held continuously for 6 transactions -> grant sequence IC, DC, INTR, IC, DC, INTR.
- Stray MEM_R=1 in IDLE with no request -> no _R pulse, GNT stays 0. Change DC_A after grant -> MEM_A keeps the original value.
- RST pulled low during REQ with a DC read outstanding -> MEM_EN=0 and GNT=0 at once; DC_R never pulses. After release, a re-asserted DC_EN is served normally.
